// File: rtl/rca_mw_seq.sv
// Multi-word add sequencer driving one external BIT_WIDTH ripple-carry adder.
// Define RCA_SEQ_OVF_EN to add the registered two's-complement overflow port ovf.
module rca_mw_seq #(
    parameter int BIT_WIDTH = 16,
    parameter int NUM_WORDS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [BIT_WIDTH*NUM_WORDS-1:0]   a_in,
    input  logic [BIT_WIDTH*NUM_WORDS-1:0]   b_in,
    input  logic                             c_in,
    output logic                             busy,
    output logic                             done,
    output logic [BIT_WIDTH*NUM_WORDS-1:0]   sum_out,
    output logic                             c_out,
`ifdef RCA_SEQ_OVF_EN
    output logic                             ovf,
`endif
    output logic [BIT_WIDTH-1:0]             rca_add_1,
    output logic [BIT_WIDTH-1:0]             rca_add_2,
    output logic                             rca_c_in,
    input  logic [BIT_WIDTH-1:0]             rca_sum,
    input  logic                             rca_c_out
);

    localparam int W  = BIT_WIDTH * NUM_WORDS;
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_nxt;
    logic           carry_reg;
    logic [IW-1:0]  idx;
    logic           last;

    assign last = (idx == IW'(NUM_WORDS - 1));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        rca_add_1 = '0;
        rca_add_2 = '0;
        rca_c_in  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = RUN;
            end
            RUN: begin
                rca_add_1 = a_reg[int'(idx)*BIT_WIDTH +: BIT_WIDTH];
                rca_add_2 = b_reg[int'(idx)*BIT_WIDTH +: BIT_WIDTH];
                rca_c_in  = carry_reg;
                acc_nxt[int'(idx)*BIT_WIDTH +: BIT_WIDTH] = rca_sum;
                if (last)
                    state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Result registers only move on the final word, so no partial sums leak out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum_out   <= '0;
            c_out     <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        carry_reg <= c_in;
                        acc       <= '0;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    acc       <= acc_nxt;
                    carry_reg <= rca_c_out;
                    if (last) begin
                        sum_out <= acc_nxt;
                        c_out   <= rca_c_out;
`ifdef RCA_SEQ_OVF_EN
                        ovf     <= (a_reg[W-1] == b_reg[W-1]) &&
                                   (rca_sum[BIT_WIDTH-1] != a_reg[W-1]);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_mw_seq.sv
// Scoreboard bench for rca_mw_seq with a behavioural 16-bit RCA attached.
module tb_rca_mw_seq;

    localparam int BW = 16;
    localparam int N  = 4;
    localparam int W  = BW * N;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          c_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum_out;
    logic          c_out;
    logic          ovf_q;
    logic [BW-1:0] rca_add_1;
    logic [BW-1:0] rca_add_2;
    logic          rca_c_in;
    logic [BW-1:0] rca_sum;
    logic          rca_c_out;

    rca_mw_seq #(.BIT_WIDTH(BW), .NUM_WORDS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .c_out     (c_out),
`ifdef RCA_SEQ_OVF_EN
        .ovf       (ovf_q),
`endif
        .rca_add_1 (rca_add_1),
        .rca_add_2 (rca_add_2),
        .rca_c_in  (rca_c_in),
        .rca_sum   (rca_sum),
        .rca_c_out (rca_c_out)
    );

`ifndef RCA_SEQ_OVF_EN
    assign ovf_q = 1'b0;
`endif

    // Combinational adder standing in for the shared RCA.
    assign {rca_c_out, rca_sum} = {1'b0, rca_add_1} + {1'b0, rca_add_2} + {16'd0, rca_c_in};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_exp = 0;
    int n_done = 0;
    logic [W+1:0]  q[$];
    logic [BW-1:0] obs_add1[N];
    logic          obs_cin[N];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [W+1:0] e;
        if (done) begin
            n_done++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done sum=%h c=%b", sum_out, c_out);
            end else begin
                e = q.pop_front();
                chk("sum_out", sum_out, e[W-1:0]);
                chk("c_out", 64'(c_out), 64'(e[W]));
`ifdef RCA_SEQ_OVF_EN
                chk("ovf", 64'(ovf_q), 64'(e[W+1]));
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge after the DUT is IDLE again.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input bit poke);
        a_in  = a;
        b_in  = b;
        c_in  = c;
        start = 1'b1;
        q.push_back({eo, ec, es});
        n_exp++;
        for (int j = 0; j <= N + 1; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start = 1'b0;
                a_in  = '0;
                b_in  = '0;
                c_in  = 1'b0;
            end
            if (j < N) begin
                obs_add1[j] = rca_add_1;
                obs_cin[j]  = rca_c_in;
            end
            if (poke && j == 1) begin
                start = 1'b1;
                a_in  = '1;
                b_in  = '1;
                c_in  = 1'b1;
            end
            if (poke && j == 2)
                start = 1'b0;
            chk("busy", 64'(busy), 64'(j <= N));
            chk("done", 64'(done), 64'(j == N));
            if (j >= N)
                chk("rca_add_1_idle", 64'(rca_add_1), 64'd0);
        end
    endtask

    initial begin
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        c_in  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", sum_out, 64'd0);
        chk("rst_c", 64'(c_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(64'd12, 64'd15, 1'b0, 64'd27, 1'b0, 1'b0, 1'b0);
        chk("add1_w0", 64'(obs_add1[0]), 64'd12);
        chk("add1_w1", 64'(obs_add1[1]), 64'd0);
        chk("add1_w2", 64'(obs_add1[2]), 64'd0);
        chk("add1_w3", 64'(obs_add1[3]), 64'd0);

        run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
        chk("cin_w0", 64'(obs_cin[0]), 64'd0);
        chk("cin_w1", 64'(obs_cin[1]), 64'd1);
        chk("cin_w2", 64'(obs_cin[2]), 64'd0);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0);
        chk("cin_ripple_w3", 64'(obs_cin[3]), 64'd1);
        run_op(64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);

        run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
               64'h2345_6789_ABCD_F001, 1'b0, 1'b0, 1'b1);
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
               64'd0, 1'b1, 1'b1, 1'b0);

        a_in  = 64'h0000_FFFF_0000_FFFF;
        b_in  = 64'd1;
        c_in  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum", sum_out, 64'd0);
        chk("abort_c", 64'(c_out), 64'd0);
        repeat (6) @(negedge clk);

        run_op(64'd5, 64'd3, 1'b0, 64'd8, 1'b0, 1'b0, 1'b0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        chk("hold_sum", sum_out, 64'h8000_0000_0000_0000);

        repeat (3) @(negedge clk);
        chk("done_count", 64'(n_done), 64'(n_exp));
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
